// File: rtl/qpsk_mapper_preambula_if.sv
// Bus between the preamble ROM builder, the QPSK mapper and the IFFT loader.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// valid never depends on ready, and a producer holds its data while ready is low.
interface qpsk_mapper_preambula_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 7
);
  logic                         enable;
  logic [1:0]                   bit_in;
  logic                         valid_in;
  logic                         ready_out;
  logic signed [DATA_WIDTH-1:0] i_out;
  logic signed [DATA_WIDTH-1:0] q_out;
  logic                         valid_out;
  logic                         ready_in;
  logic [IDX_WIDTH-1:0]         sym_idx;
  logic                         sop_out;
  logic                         eop_out;
  logic [7:0]                   frame_cnt;
  logic [1:0]                   dbg_count;

  modport master (
    output enable, bit_in, valid_in, ready_in,
    input  ready_out, i_out, q_out, valid_out, sym_idx, sop_out, eop_out,
           frame_cnt, dbg_count
  );

  modport slave (
    input  enable, bit_in, valid_in, ready_in,
    output ready_out, i_out, q_out, valid_out, sym_idx, sop_out, eop_out,
           frame_cnt, dbg_count
  );
endinterface

// File: rtl/qpsk_mapper_preambula.sv
// Gray-maps 2-bit preamble pairs to QPSK I/Q samples and buffers them in a
// 2-entry FIFO tagged with subcarrier index and start/end-of-symbol flags.
module qpsk_mapper_preambula #(
  parameter int DATA_WIDTH = 16,
  parameter int AMP        = 11585,
  parameter int N_SYM      = 64,
  parameter int IDX_WIDTH  = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  qpsk_mapper_preambula_if.slave   bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] i;
    logic [DATA_WIDTH-1:0] q;
    logic [IDX_WIDTH-1:0]  idx;
    logic                  sop;
    logic                  eop;
  } entry_t;

  localparam logic [DATA_WIDTH-1:0] AMP_P    = DATA_WIDTH'(AMP);
  localparam logic [DATA_WIDTH-1:0] AMP_N    = ~AMP_P + DATA_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(N_SYM - 1);

  logic [1:0]           r_count;
  entry_t               r_head;
  entry_t               r_tail;
  logic [IDX_WIDTH-1:0] r_wr_idx;
  logic [7:0]           r_frame_cnt;

  logic                 w_ready;
  logic                 w_push;
  logic                 w_pop;
  entry_t               w_new;
  logic [1:0]           w_count_nxt;
  entry_t               w_head_nxt;
  entry_t               w_tail_nxt;
  logic [IDX_WIDTH-1:0] w_wr_idx_nxt;

  // ready_out looks only at registered occupancy, never at ready_in
  assign w_ready = bus.enable && (r_count != 2'd2);
  assign w_push  = bus.valid_in && w_ready;
  assign w_pop   = (r_count != 2'd0) && bus.ready_in;

  // bit 0 -> sign of I, bit 1 -> sign of Q, 1 means negative
  always_comb begin
    w_new     = '0;
    w_new.i   = bus.bit_in[0] ? AMP_N : AMP_P;
    w_new.q   = bus.bit_in[1] ? AMP_N : AMP_P;
    w_new.idx = r_wr_idx;
    w_new.sop = (r_wr_idx == '0);
    w_new.eop = (r_wr_idx == LAST_IDX);
  end

  always_comb begin
    w_wr_idx_nxt = r_wr_idx;
    if (w_push) begin
      w_wr_idx_nxt = (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + IDX_WIDTH'(1);
    end
  end

  // Head entry always drives the outputs, so it is left untouched when the
  // buffer empties; that gives the hold-last-value behaviour for free.
  always_comb begin
    w_count_nxt = r_count;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    case (r_count)
      2'd0: begin
        if (w_push) begin
          w_head_nxt  = w_new;
          w_count_nxt = 2'd1;
        end
      end
      2'd1: begin
        case ({w_push, w_pop})
          2'b11: w_head_nxt = w_new;
          2'b10: begin
            w_tail_nxt  = w_new;
            w_count_nxt = 2'd2;
          end
          2'b01: w_count_nxt = 2'd0;
          default: ;
        endcase
      end
      2'd2: begin
        if (w_pop) begin
          w_head_nxt  = r_tail;
          w_count_nxt = 2'd1;
        end
      end
      default: w_count_nxt = 2'd0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count     <= 2'd0;
      r_head      <= '0;
      r_tail      <= '0;
      r_wr_idx    <= '0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_count  <= w_count_nxt;
      r_head   <= w_head_nxt;
      r_tail   <= w_tail_nxt;
      r_wr_idx <= w_wr_idx_nxt;
      if (w_pop && r_head.eop) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign bus.ready_out = w_ready;
  assign bus.valid_out = (r_count != 2'd0);
  assign bus.i_out     = r_head.i;
  assign bus.q_out     = r_head.q;
  assign bus.sym_idx   = r_head.idx;
  assign bus.sop_out   = r_head.sop;
  assign bus.eop_out   = r_head.eop;
  assign bus.frame_cnt = r_frame_cnt;
  assign bus.dbg_count = r_count;

endmodule

// File: tb/tb_qpsk_mapper_preambula.sv
// Directed table plus multi-cycle sequences and a scoreboarded random run
// for the QPSK preamble mapper.
module tb_qpsk_mapper_preambula;

  localparam logic [15:0] P = 16'd11585;
  localparam logic [15:0] N = 16'hD2BF;

  typedef struct {
    logic        en;
    logic        vin;
    logic [1:0]  bits;
    logic        rin;
    logic        exp_rdy;
    logic        exp_vld;
    logic [15:0] exp_i;
    logic [15:0] exp_q;
    logic [6:0]  exp_idx;
    logic        exp_sop;
    logic        exp_eop;
  } vec_t;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_miss;
  vec_t vecs[14];

  logic [40:0] exp_q[$];
  logic [40:0] popped;
  logic [40:0] prev_head;
  logic        prev_hold;
  int          m_idx;
  int          m_frame;
  logic        m_push;
  logic        m_pop;

  qpsk_mapper_preambula_if #(.DATA_WIDTH(16), .IDX_WIDTH(7)) bus ();

  qpsk_mapper_preambula #(
    .DATA_WIDTH(16),
    .AMP       (11585),
    .N_SYM     (64),
    .IDX_WIDTH (7)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int en, input int vin, input int bits, input int rin,
                              input int rdy, input int vld, input logic [15:0] ei,
                              input logic [15:0] eq, input int idx, input int sop, input int eop);
    vec_t v;
    v.en = 1'(en); v.vin = 1'(vin); v.bits = 2'(bits); v.rin = 1'(rin);
    v.exp_rdy = 1'(rdy); v.exp_vld = 1'(vld); v.exp_i = ei; v.exp_q = eq;
    v.exp_idx = 7'(idx); v.exp_sop = 1'(sop); v.exp_eop = 1'(eop);
    return v;
  endfunction

  function automatic logic [40:0] model_entry(input logic [1:0] b, input int idx);
    logic [15:0] ei;
    logic [15:0] eq;
    logic [6:0]  ix;
    ei = b[0] ? N : P;
    eq = b[1] ? N : P;
    ix = 7'(idx);
    return {ei, eq, ix, (idx == 0), (idx == 63)};
  endfunction

  function automatic logic [40:0] dut_head();
    return {bus.i_out, bus.q_out, bus.sym_idx, bus.sop_out, bus.eop_out};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic vin, input logic [1:0] b, input logic rin);
    bus.enable   = en;
    bus.valid_in = vin;
    bus.bit_in   = b;
    bus.ready_in = rin;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    drive(1'b1, 1'b0, 2'd0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk({tag, "_valid"},  64'(bus.valid_out), 64'd0);
    chk({tag, "_i"},      64'(bus.i_out),     64'd0);
    chk({tag, "_q"},      64'(bus.q_out),     64'd0);
    chk({tag, "_idx"},    64'(bus.sym_idx),   64'd0);
    chk({tag, "_sopeop"}, 64'({bus.sop_out, bus.eop_out}), 64'd0);
    chk({tag, "_frame"},  64'(bus.frame_cnt), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk({tag, "_ready_after"}, 64'(bus.ready_out), 64'd1);
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    apply_reset("reset0");

    // Mapping, backpressure and enable table: inputs, pre-edge ready, post-edge head
    vecs[0]  = mk(1, 1, 0, 1,  1, 1, P, P, 0, 1, 0);
    vecs[1]  = mk(1, 1, 1, 1,  1, 1, N, P, 1, 0, 0);
    vecs[2]  = mk(1, 1, 2, 1,  1, 1, P, N, 2, 0, 0);
    vecs[3]  = mk(1, 1, 3, 1,  1, 1, N, N, 3, 0, 0);
    vecs[4]  = mk(1, 0, 0, 1,  1, 0, N, N, 3, 0, 0);
    vecs[5]  = mk(1, 1, 0, 0,  1, 1, P, P, 4, 0, 0);
    vecs[6]  = mk(1, 1, 1, 0,  1, 1, P, P, 4, 0, 0);
    vecs[7]  = mk(1, 1, 2, 0,  0, 1, P, P, 4, 0, 0);
    vecs[8]  = mk(1, 1, 2, 1,  0, 1, N, P, 5, 0, 0);
    vecs[9]  = mk(1, 1, 2, 1,  1, 1, P, N, 6, 0, 0);
    vecs[10] = mk(1, 0, 0, 1,  1, 0, P, N, 6, 0, 0);
    vecs[11] = mk(0, 1, 3, 1,  0, 0, P, N, 6, 0, 0);
    vecs[12] = mk(1, 1, 3, 1,  1, 1, N, N, 7, 0, 0);
    vecs[13] = mk(1, 0, 0, 1,  1, 0, N, N, 7, 0, 0);

    for (int k = 0; k < 14; k++) begin
      drive(vecs[k].en, vecs[k].vin, vecs[k].bits, vecs[k].rin);
      #1;
      chk($sformatf("vec%0d_ready", k), 64'(bus.ready_out), 64'(vecs[k].exp_rdy));
      tick();
      chk($sformatf("vec%0d_valid", k), 64'(bus.valid_out), 64'(vecs[k].exp_vld));
      chk($sformatf("vec%0d_head", k), 64'(dut_head()),
          64'({vecs[k].exp_i, vecs[k].exp_q, vecs[k].exp_idx, vecs[k].exp_sop, vecs[k].exp_eop}));
    end

    // Reset with two buffered entries: they must vanish
    drive(1'b1, 1'b1, 2'd1, 1'b0);
    tick();
    tick();
    chk("prefill_count", 64'(bus.dbg_count), 64'd2);
    apply_reset("reset1");

    // Framing: 130 pairs streamed at full rate
    for (int k = 0; k < 130; k++) begin
      drive(1'b1, 1'b1, 2'(k % 4), 1'b1);
      tick();
      chk($sformatf("frame%0d_valid", k), 64'(bus.valid_out), 64'd1);
      chk($sformatf("frame%0d_head", k), 64'(dut_head()), 64'(model_entry(2'(k % 4), k % 64)));
      if (k == 100) chk("frame_cnt_mid", 64'(bus.frame_cnt), 64'd1);
    end
    drive(1'b1, 1'b0, 2'd0, 1'b1);
    tick();
    chk("frame_drain_valid", 64'(bus.valid_out), 64'd0);
    chk("frame_cnt_end", 64'(bus.frame_cnt), 64'd2);

    // Reset mid-frame with frame_cnt nonzero and one entry buffered
    drive(1'b1, 1'b1, 2'd3, 1'b0);
    tick();
    chk("midframe_head_idx", 64'(bus.sym_idx), 64'd2);
    apply_reset("reset2");
    drive(1'b1, 1'b1, 2'd0, 1'b1);
    tick();
    chk("post_reset_head", 64'({bus.valid_out, dut_head()}), 64'({1'b1, model_entry(2'd0, 0)}));

    // Enable gating at wr_idx = 10
    for (int k = 1; k < 10; k++) begin
      drive(1'b1, 1'b1, 2'(k % 4), 1'b1);
      tick();
    end
    chk("gate_pre_idx", 64'(bus.sym_idx), 64'd9);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 2'd3, 1'b1);
      #1;
      chk($sformatf("gate%0d_ready", k), 64'(bus.ready_out), 64'd0);
      tick();
      chk($sformatf("gate%0d_valid", k), 64'(bus.valid_out), 64'd0);
    end
    drive(1'b1, 1'b1, 2'd2, 1'b1);
    tick();
    chk("gate_resume_head", 64'({bus.valid_out, dut_head()}), 64'({1'b1, model_entry(2'd2, 10)}));
    drive(1'b1, 1'b0, 2'd0, 1'b1);
    tick();

    // Random stress against the scoreboard
    apply_reset("reset3");
    exp_q.delete();
    m_idx     = 0;
    m_frame   = 0;
    prev_hold = 1'b0;
    prev_head = '0;
    for (int c = 0; c < 1000; c++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      #1;
      chk("rnd_ready", 64'(bus.ready_out), 64'(exp_q.size() != 2));
      m_push = bus.valid_in && (exp_q.size() != 2);
      m_pop  = (exp_q.size() != 0) && bus.ready_in;
      prev_hold = (exp_q.size() != 0) && !bus.ready_in;
      prev_head = dut_head();
      if (m_pop) begin
        popped = exp_q.pop_front();
        if (popped[0]) m_frame = (m_frame + 1) % 256;
      end
      if (m_push) begin
        exp_q.push_back(model_entry(bus.bit_in, m_idx));
        m_idx = (m_idx + 1) % 64;
      end
      tick();
      chk("rnd_count", 64'(bus.dbg_count), 64'(exp_q.size()));
      chk("rnd_valid", 64'(bus.valid_out), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("rnd_head", 64'(dut_head()), 64'(exp_q[0]));
      if (prev_hold) chk("rnd_stable", 64'(dut_head()), 64'(prev_head));
    end
    chk("rnd_frame_cnt", 64'(bus.frame_cnt), 64'(m_frame));

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
